// File: rtl/seg7_scan.sv
// seg7_scan: eight-digit multiplexed seven-segment scanner with blanking
// between digit slots and frame-synchronous double-buffered display data.
module seg7_scan #(
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scan_clk_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  dp_i,
  input  logic [7:0]  en_i,
  input  logic        load_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [2:0]  digit_idx_o,
  output logic        frame_o
);

  typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} state_t;

  localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES - 1);

  // Active-low {g..a} pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  state_t      state_r, state_n;
  logic        scan_q;
  logic [7:0]  cnt_r, cnt_n;
  logic [2:0]  idx_r, idx_n;
  logic        frame_r;
  logic        wrap_s, tick_s;
  logic        pend_r, pend_n;
  logic [31:0] pend_data_r, pend_data_n;
  logic [7:0]  pend_dp_r, pend_dp_n, pend_en_r, pend_en_n;
  logic [31:0] sh_data_r, sh_data_n;
  logic [7:0]  sh_dp_r, sh_dp_n, sh_en_r, sh_en_n;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  assign tick_s = scan_clk_i & ~scan_q;

  // Slot sequencing: SHOW waits for a tick, BLANK counts down the gap.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    idx_n   = idx_r;
    wrap_s  = 1'b0;
    case (state_r)
      SHOW: begin
        if (tick_s) begin
          state_n = BLANK;
          cnt_n   = BLANK_LOAD;
          idx_n   = idx_r + 3'd1;
          wrap_s  = (idx_r == 3'd7);
        end else begin
          state_n = SHOW;
        end
      end
      BLANK: begin
        if (cnt_r == 8'd0) begin
          state_n = SHOW;
        end else begin
          cnt_n = cnt_r - 8'd1;
        end
      end
      default: begin
        state_n = SHOW;
        cnt_n   = 8'd0;
      end
    endcase
  end

  // Double buffering: pending captures loads, shadow only changes on a wrap.
  always_comb begin
    pend_n      = pend_r;
    pend_data_n = pend_data_r;
    pend_dp_n   = pend_dp_r;
    pend_en_n   = pend_en_r;
    sh_data_n   = sh_data_r;
    sh_dp_n     = sh_dp_r;
    sh_en_n     = sh_en_r;
    if (wrap_s && load_i) begin
      sh_data_n = data_i;
      sh_dp_n   = dp_i;
      sh_en_n   = en_i;
      pend_n    = 1'b0;
    end else if (wrap_s && pend_r) begin
      sh_data_n = pend_data_r;
      sh_dp_n   = pend_dp_r;
      sh_en_n   = pend_en_r;
      pend_n    = 1'b0;
    end else if (load_i) begin
      pend_data_n = data_i;
      pend_dp_n   = dp_i;
      pend_en_n   = en_i;
      pend_n      = 1'b1;
    end else begin
      pend_n = pend_r;
    end
  end

  // Display drive computed from next-cycle state so outputs line up with it.
  always_comb begin
    an_n  = 8'hFF;
    seg_n = 7'h7F;
    dp_n  = 1'b1;
    if (state_n == SHOW && sh_en_n[idx_n]) begin
      an_n  = ~(8'h01 << idx_n);
      seg_n = hex_to_seg(sh_data_n[{idx_n, 2'b00} +: 4]);
      dp_n  = ~sh_dp_n[idx_n];
    end else begin
      an_n  = 8'hFF;
      seg_n = 7'h7F;
      dp_n  = 1'b1;
    end
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= SHOW;
      scan_q      <= 1'b0;
      cnt_r       <= 8'd0;
      idx_r       <= 3'd0;
      frame_r     <= 1'b0;
      pend_r      <= 1'b0;
      pend_data_r <= 32'd0;
      pend_dp_r   <= 8'd0;
      pend_en_r   <= 8'd0;
      sh_data_r   <= 32'd0;
      sh_dp_r     <= 8'd0;
      sh_en_r     <= 8'd0;
      an_o        <= 8'hFF;
      seg_o       <= 7'h7F;
      dp_o        <= 1'b1;
    end else begin
      state_r     <= state_n;
      scan_q      <= scan_clk_i;
      cnt_r       <= cnt_n;
      idx_r       <= idx_n;
      frame_r     <= wrap_s;
      pend_r      <= pend_n;
      pend_data_r <= pend_data_n;
      pend_dp_r   <= pend_dp_n;
      pend_en_r   <= pend_en_n;
      sh_data_r   <= sh_data_n;
      sh_dp_r     <= sh_dp_n;
      sh_en_r     <= sh_en_n;
      an_o        <= an_n;
      seg_o       <= seg_n;
      dp_o        <= dp_n;
    end
  end

  assign digit_idx_o = idx_r;
  assign frame_o     = frame_r;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan.
module tb_seg7_scan;

  localparam int BC = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        scan_clk_i = 1'b0;
  logic [31:0] data_i = 32'd0;
  logic [7:0]  dp_i = 8'd0;
  logic [7:0]  en_i = 8'd0;
  logic        load_i = 1'b0;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [2:0]  digit_idx_o;
  logic        frame_o;

  int n_cmp = 0;
  int n_bad = 0;
  int frame_cnt = 0;

  seg7_scan #(.BLANK_CYCLES(BC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .scan_clk_i(scan_clk_i),
    .data_i(data_i), .dp_i(dp_i), .en_i(en_i), .load_i(load_i),
    .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o),
    .digit_idx_o(digit_idx_o), .frame_o(frame_o)
  );

  always #5 clk_i = ~clk_i;

  // Count frame pulses as seen mid-cycle.
  always @(negedge clk_i) begin
    if (frame_o) frame_cnt <= frame_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle scan clock pulse; returns on the negedge after the tick edge.
  task automatic drive_tick(input logic with_load, input logic [31:0] d,
                            input logic [7:0] e, input logic [7:0] p);
    @(negedge clk_i);
    scan_clk_i = 1'b1;
    if (with_load) begin
      load_i = 1'b1; data_i = d; en_i = e; dp_i = p;
    end
    @(negedge clk_i);
    scan_clk_i = 1'b0;
    load_i = 1'b0;
  endtask

  // Tick and wait until the slot is back in SHOW.
  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      drive_tick(1'b0, 32'd0, 8'd0, 8'd0);
      repeat (BC) @(negedge clk_i);
    end
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
    @(negedge clk_i);
    load_i = 1'b1; data_i = d; en_i = e; dp_i = p;
    @(negedge clk_i);
    load_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_an", an_o, 32'hFF);
    check("rst_seg", seg_o, 32'h7F);
    check("rst_dp", dp_o, 32'h1);
    check("rst_idx", digit_idx_o, 32'h0);
    check("rst_frame", frame_o, 32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Scenario: load then 9 ticks; dark until wrap
    load(32'h76543210, 8'hFF, 8'h00);
    check("s1_dark0", an_o, 32'hFF);
    advance(3);
    check("s1_idx3", digit_idx_o, 32'h3);
    check("s1_dark3", an_o, 32'hFF);
    advance(4);
    drive_tick(1'b0, 32'd0, 8'd0, 8'd0);
    check("s1_frame_hi", frame_o, 32'h1);
    check("s1_idx_wrap", digit_idx_o, 32'h0);
    @(negedge clk_i);
    check("s1_frame_lo", frame_o, 32'h0);
    repeat (BC - 1) @(negedge clk_i);
    check("s1_an0", an_o, 32'hFE);
    check("s1_seg0", seg_o, 32'h40);
    check("s1_dp0", dp_o, 32'h1);
    advance(1);
    check("s1_an1", an_o, 32'hFD);
    check("s1_seg1", seg_o, 32'h79);

    // Scenario: blank length exactly BC cycles, tick during BLANK ignored
    drive_tick(1'b0, 32'd0, 8'd0, 8'd0);
    for (int i = 0; i < BC; i++) begin
      check("s2_blank", an_o, 32'hFF);
      if (i == 1) begin
        scan_clk_i = 1'b1;
      end else begin
        scan_clk_i = 1'b0;
      end
      @(negedge clk_i);
    end
    check("s2_an2", an_o, 32'hFB);
    check("s2_seg2", seg_o, 32'h24);
    check("s2_idx_hold", digit_idx_o, 32'h2);

    // Scenario: partial enables and decimal point
    do_reset();
    load(32'h0000000A, 8'h0F, 8'h01);
    advance(8);
    check("s3_an0", an_o, 32'hFE);
    check("s3_seg0", seg_o, 32'h08);
    check("s3_dp0", dp_o, 32'h0);
    advance(1);
    check("s3_dp1", dp_o, 32'h1);
    check("s3_seg1", seg_o, 32'h40);
    advance(3);
    for (int k = 4; k < 8; k++) begin
      check("s3_off", an_o, 32'hFF);
      advance(1);
    end
    check("s3_an0b", an_o, 32'hFE);

    // Scenario: two loads before a wrap, last wins; one frame per 8 ticks
    do_reset();
    frame_cnt = 0;
    advance(3);
    load(32'h11111111, 8'hFF, 8'h00);
    advance(2);
    load(32'h22222222, 8'hFF, 8'h00);
    advance(1);
    check("s4_dark6", an_o, 32'hFF);
    advance(2);
    check("s4_frames1", frame_cnt, 32'd1);
    check("s4_seg0", seg_o, 32'h24);
    advance(1);
    check("s4_seg1", seg_o, 32'h24);
    advance(8);
    check("s4_frames2", frame_cnt, 32'd2);
    check("s4_idx", digit_idx_o, 32'h1);

    // Scenario: load coincident with wrap goes straight to shadow
    advance(6);
    check("s5_idx7", digit_idx_o, 32'h7);
    drive_tick(1'b1, 32'hFFFFFFFF, 8'hFF, 8'h00);
    repeat (BC) @(negedge clk_i);
    check("s5_an0", an_o, 32'hFE);
    check("s5_seg0", seg_o, 32'h0E);
    advance(8);
    check("s5_seg0_next", seg_o, 32'h0E);

    // Scenario: reset during BLANK at index 5
    advance(4);
    drive_tick(1'b0, 32'd0, 8'd0, 8'd0);
    check("s6_idx5", digit_idx_o, 32'h5);
    rst_i = 1'b1;
    #1;
    check("s6_idx_rst", digit_idx_o, 32'h0);
    check("s6_an_rst", an_o, 32'hFF);
    check("s6_seg_rst", seg_o, 32'h7F);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("s6_idx_rel", digit_idx_o, 32'h0);
    check("s6_dark", an_o, 32'hFF);
    advance(1);
    check("s6_idx1", digit_idx_o, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter: BLANK_CYCLES, default 4, number of clk_i cycles during which all anodes are off between digit slots; legal range 1..255.
REQ-002 Port: clk_i  input  1  system clock (25 MHz).
REQ-003 Port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 Port: scan_clk_i  input  1  refresh clock from the 1 kHz divider, generated in the clk_i domain; its rising edge advances the digit slot.
REQ-005 Port: data_i  input  32  eight hex nibbles; nibble k = data_i[4k+3:4k] is shown on digit k.
REQ-006 Port: dp_i  input  8  decimal point request per digit, 1 = lit.
REQ-007 Port: en_i  input  8  digit enable per digit, 1 = digit may be lit.
REQ-008 Port: load_i  input  1  single-cycle strobe; captures data_i, dp_i and en_i.
REQ-009 Port: an_o  output  8  anode selects, active-low, bit k = digit k.
REQ-010 Port: seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 Port: dp_o  output  1  decimal point, active-low.
REQ-012 Port: digit_idx_o  output  3  index of the current slot.
REQ-013 Port: frame_o  output  1  one-cycle pulse when the slot index wraps from 7 to 0.

Function
REQ-014 scan_clk_i shall be registered once (scan_q); the scan tick shall be scan_clk_i & ~scan_q, with exactly one tick per rising edge.
REQ-015 The FSM shall have two states: SHOW (one anode driven) and BLANK (an_o = 8'hFF, seg_o = 7'h7F, dp_o = 1).
REQ-016 In SHOW, a tick shall move the FSM to BLANK, load the blank counter with BLANK_CYCLES-1, and advance digit_idx_o by 1 modulo 8 in the same cycle.
REQ-017 In BLANK, the counter shall decrement each cycle; when it reaches 0, the FSM shall return to SHOW on the next edge, so the blank interval is exactly BLANK_CYCLES cycles.
REQ-018 A tick arriving while the FSM is in BLANK shall be ignored; the index shall not advance.
REQ-019 In SHOW with shadow enable bit k = 1 at index k, an_o shall have only bit k low, seg_o shall carry the hex encoding of shadow nibble k, and dp_o shall be ~shadow_dp[k].
REQ-020 In SHOW with shadow enable bit k = 0, the outputs shall hold blank values for that slot; the slot still consumes one tick period.
REQ-021 Hex encoding (active-low {g..a}): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-022 Outputs an_o, seg_o and dp_o shall be registered, with no combinational path from the inputs.
REQ-023 load_i shall capture data_i, dp_i and en_i into pending registers and set a pending flag.
REQ-024 When the index wraps from 7 to 0 and the pending flag is set, pending shall be copied to the shadow registers and the flag cleared, so a frame is never torn.
REQ-025 If load_i coincides with a wrap, the data presented with load_i shall go directly to shadow, and the flag shall end cleared.
REQ-026 If load_i occurs twice before a wrap, the last value shall win.
REQ-027 frame_o shall be high for exactly the cycle in which the index changes from 7 to 0.

Reset
REQ-028 While rst_i is high, the block shall drive an_o = 8'hFF, seg_o = 7'h7F, dp_o = 1, digit_idx_o = 0 and frame_o = 0, with the FSM in SHOW.
REQ-029 While rst_i is high, the block shall hold scan_q = 0, blank counter = 0, pending flag = 0, and all pending and shadow registers = 0; with shadow enables at 0, the display stays dark until the first load reaches shadow.
REQ-030 Reset asserted mid-BLANK or mid-frame shall take effect immediately; after release, scanning shall restart at index 0.

Verification
REQ-031 Scenario: reset, then load_i with data_i = 32'h76543210, en_i = FF, dp_i = 00, then drive 9 ticks -> display dark until wrap; after wrap, digit 0 shows an_o = FE and seg_o = 40, and digit 1 shows an_o = FD and seg_o = 79.
REQ-032 Scenario: BLANK_CYCLES = 4, one tick -> an_o = FF for exactly 4 cycles, then next anode low; a second tick injected during BLANK -> no index change.
REQ-033 Scenario: en_i = 8'h0F, dp_i = 8'h01, data 0000_000A -> slots 4..7 have an_o = FF; slot 0 shows seg_o = 08 and dp_o = 0.
REQ-034 Scenario: load A at index 3, load B at index 5, no further load -> the frame after the wrap shows B only; frame_o pulses once per 8 ticks.
REQ-035 Scenario: load_i in the same cycle as the 7->0 wrap with data 32'hFFFFFFFF -> digit 0 shows seg_o = 0E in that frame.
REQ-036 Scenario: assert rst_i during BLANK at index 5 -> outputs take reset values immediately, and digit_idx_o = 0 after release.
